// File: rtl/quad_encoder_mc.sv
// rtl/quad_encoder_mc.sv - multi-channel quadrature decoder with filter, position, direction, error and velocity
//
// Each channel synchronises and glitch-filters its A/B pins. It then decodes
// Gray-code steps into a wrapping signed position, a direction with idle
// timeout, and a sticky illegal-transition flag. A single global window
// counter drives per-channel signed velocity snapshots.
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   enc_a/enc_b raw encoder pins, bit i = channel i
//   mode        count mode for all channels: 00/11=x4, 01=x2, 10=x1
//   pos_clr     per-channel synchronous position clear
//   err_clr     per-channel clear of the sticky error flag
//   dir         2 bits per channel: 01=CW, 11=CCW, 00=idle
//   position    POS_W bits per channel, signed, wrapping
//   velocity    VEL_W bits per channel, signed counts per window
//   vel_valid   one-cycle pulse when velocity is refreshed
//   err         per-channel sticky illegal-transition flag
module quad_encoder_mc #(
  parameter int NUM_CH     = 2,
  parameter int POS_W      = 32,
  parameter int VEL_W      = 16,
  parameter int FILT_LEN   = 4,
  parameter int IDLE_CYC   = 500_000,
  parameter int VEL_PERIOD = 50_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         enc_a,
  input  logic [NUM_CH-1:0]         enc_b,
  input  logic [1:0]                mode,
  input  logic [NUM_CH-1:0]         pos_clr,
  input  logic [NUM_CH-1:0]         err_clr,
  output logic [2*NUM_CH-1:0]       dir,
  output logic [POS_W*NUM_CH-1:0]   position,
  output logic [VEL_W*NUM_CH-1:0]   velocity,
  output logic                      vel_valid,
  output logic [NUM_CH-1:0]         err
);

  // The filter counter only has to reach FILT_LEN-1.
  localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int IDLE_W = $clog2(IDLE_CYC + 1);
  localparam int WIN_W  = $clog2(VEL_PERIOD);
  localparam logic signed [VEL_W:0] VEL_MAX = {2'b00, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W:0] VEL_MIN = -VEL_MAX;

  // The CW successor of a {A,B} state: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      2'b00:   cw_next = 2'b10;
      2'b10:   cw_next = 2'b11;
      2'b11:   cw_next = 2'b01;
      default: cw_next = 2'b00;
    endcase
  endfunction

  logic [WIN_W-1:0] win_cnt;
  logic             win_last;

  assign win_last = (win_cnt == WIN_W'(VEL_PERIOD - 1));

  // vel_valid is registered so that it lines up with the velocity registers
  // that load on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt   <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= win_last;
      win_cnt   <= win_last ? '0 : win_cnt + 1'b1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [1:0]              raw, sync1, sync2, filt, prev_s;
    logic [FCNT_W-1:0]       fcnt [2];
    logic                    changed, illegal, step_cw, step_ccw, qualify;
    logic                    cnt_up, cnt_dn;
    logic [POS_W-1:0]        pos_q;
    logic [1:0]              dir_q;
    logic [IDLE_W-1:0]       idle_cnt;
    logic                    err_q;
    logic signed [VEL_W-1:0] acc_q, vel_q, acc_sat;
    logic signed [VEL_W:0]   acc_sum;

    assign raw = {enc_a[ch], enc_b[ch]};

    // Bit 1 is A, bit 0 is B. A level is accepted only after the
    // synchronised input has disagreed with it for FILT_LEN straight cycles.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1   <= '0;
        sync2   <= '0;
        filt    <= '0;
        fcnt[0] <= '0;
        fcnt[1] <= '0;
      end else begin
        sync1 <= raw;
        sync2 <= sync1;
        for (int j = 0; j < 2; j++) begin
          if (sync2[j] == filt[j]) begin
            fcnt[j] <= '0;
          end else if (fcnt[j] == FCNT_W'(FILT_LEN - 1)) begin
            filt[j] <= sync2[j];
            fcnt[j] <= '0;
          end else begin
            fcnt[j] <= fcnt[j] + 1'b1;
          end
        end
      end
    end

    always_comb begin
      changed  = (filt != prev_s);
      illegal  = (filt == ~prev_s);
      step_cw  = changed && (filt == cw_next(prev_s));
      step_ccw = changed && (prev_s == cw_next(filt));
      case (mode)
        2'b01:   qualify = filt[1] ^ prev_s[1];
        2'b10:   qualify = (filt == 2'b00);
        default: qualify = 1'b1;
      endcase
      cnt_up  = step_cw & qualify;
      cnt_dn  = step_ccw & qualify;
      acc_sum = {acc_q[VEL_W-1], acc_q};
      if (cnt_up) begin
        acc_sum = acc_sum + (VEL_W+1)'(1);
      end else if (cnt_dn) begin
        acc_sum = acc_sum - (VEL_W+1)'(1);
      end
      if (acc_sum > VEL_MAX) begin
        acc_sat = VEL_MAX[VEL_W-1:0];
      end else if (acc_sum < VEL_MIN) begin
        acc_sat = VEL_MIN[VEL_W-1:0];
      end else begin
        acc_sat = acc_sum[VEL_W-1:0];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prev_s   <= '0;
        pos_q    <= '0;
        dir_q    <= '0;
        idle_cnt <= '0;
        err_q    <= 1'b0;
        acc_q    <= '0;
        vel_q    <= '0;
      end else begin
        prev_s <= filt;
        // Clear wins for position only; the step still reaches the accumulator.
        if (pos_clr[ch]) begin
          pos_q <= '0;
        end else if (cnt_up) begin
          pos_q <= pos_q + 1'b1;
        end else if (cnt_dn) begin
          pos_q <= pos_q - 1'b1;
        end
        if (step_cw || step_ccw) begin
          dir_q    <= step_cw ? 2'b01 : 2'b11;
          idle_cnt <= '0;
        end else begin
          if (idle_cnt != IDLE_W'(IDLE_CYC)) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          // Drop to idle on the edge where the counter reaches IDLE_CYC.
          if (idle_cnt >= IDLE_W'(IDLE_CYC - 1)) begin
            dir_q <= 2'b00;
          end
        end
        if (illegal) begin
          err_q <= 1'b1;
        end else if (err_clr[ch]) begin
          err_q <= 1'b0;
        end
        if (win_last) begin
          vel_q <= acc_sat;
          acc_q <= '0;
        end else begin
          acc_q <= acc_sat;
        end
      end
    end

    assign dir[2*ch +: 2]            = dir_q;
    assign position[POS_W*ch +: POS_W] = pos_q;
    assign velocity[VEL_W*ch +: VEL_W] = vel_q;
    assign err[ch]                   = err_q;
  end

endmodule
